// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: funct3 op encoding, FSM states and
// small operand helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step.
// The *_nxt outputs expose the post-step values so the caller can capture the final step.
module mdu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_nxt_o,
  output logic [31:0] rem_nxt_o
);

  logic [31:0] rem_q, quot_q, dvsr_q;
  logic [32:0] shifted, diff;
  logic        fits;

  always_comb begin
    shifted    = {rem_q, quot_q[31]};
    diff       = shifted - {1'b0, dvsr_q};
    // No borrow out of the 33-bit subtract means the divisor fits.
    fits       = ~diff[32];
    rem_nxt_o  = fits ? diff[31:0] : shifted[31:0];
    quot_nxt_o = {quot_q[30:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (init_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_nxt_o;
      quot_q <= quot_nxt_o;
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit (IDLE -> CALC x32 -> DONE). Build option MDU_FAST_MUL_EN
// enables a combinational 33x33 multiplier so multiplies finish one cycle after START.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MDU_START_i,
  input  logic        MDU_FLUSH_i,
  input  logic [2:0]  MDU_OP_i,
  input  logic [31:0] MDU_RS1_i,
  input  logic [31:0] MDU_RS2_i,
  output logic        MDU_BUSY_o,
  output logic        MDU_DONE_o,
  output logic [31:0] MDU_RD_o
);

  mdu_state_t  state_q, state_d;
  mdu_op_t     op_q, op_d, op_in;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d, prod_step, prod_fix;
  logic        neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic [31:0] rd_q, rd_d, result;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, quot_nxt, rem_nxt, quot_fix, rem_fix;
  logic [32:0] mul_sum;
  logic        div_init, div_step;

  assign op_in = mdu_op_t'(MDU_OP_i);

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OpMulh, OpDiv, OpRem: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OpMulhsu: a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & MDU_RS1_i[31];
    b_neg = b_signed & MDU_RS2_i[31];
    a_mag = mag(MDU_RS1_i, a_neg);
    b_mag = mag(MDU_RS2_i, b_neg);
  end

  // Shift-add multiply: multiplier sits in prod_q[31:0] and drains out as the product fills in.
  always_comb begin
    mul_sum   = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
    prod_step = {mul_sum, prod_q[31:1]};
  end

  mdu_divider u_divider (
    .clk        (clk),
    .rst        (rst),
    .init_i     (div_init),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_nxt_o (quot_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
  always_comb begin
    prod_fix = neg_q ? (~prod_step + 64'd1) : prod_step;
    quot_fix = (neg_q && !div0_q) ? (~quot_nxt + 32'd1) : quot_nxt;
    rem_fix  = rem_neg_q ? (~rem_nxt + 32'd1) : rem_nxt;
    case (op_q)
      OpMul:                    result = prod_fix[31:0];
      OpMulh, OpMulhsu, OpMulhu: result = prod_fix[63:32];
      OpDiv, OpDivu:            result = quot_fix;
      default:                  result = rem_fix;
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [65:0] fast_prod;
  logic [31:0]        fast_res;
  logic               unused_fast_hi;

  always_comb begin
    fast_a    = {a_neg, MDU_RS1_i};
    fast_b    = {b_neg, MDU_RS2_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (op_in == OpMul) ? fast_prod[31:0] : fast_prod[63:32];
  end
  assign unused_fast_hi = ^fast_prod[65:64];
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    rd_d      = rd_q;
    div_init  = 1'b0;
    div_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MDU_START_i && !MDU_FLUSH_i) begin
          op_d      = op_in;
          cnt_d     = 5'd0;
          mcand_d   = a_mag;
          prod_d    = {32'd0, b_mag};
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = is_div(op_in) && (MDU_RS2_i == 32'd0);
          div_init  = 1'b1;
          state_d   = StCalc;
`ifdef MDU_FAST_MUL_EN
          if (!is_div(op_in)) begin
            rd_d    = fast_res;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (MDU_FLUSH_i) begin
          state_d = StIdle;
        end else begin
          div_step = 1'b1;
          prod_d   = prod_step;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            rd_d    = result;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      rd_q      <= rd_d;
    end
  end

  assign MDU_BUSY_o = (state_q != StIdle);
  assign MDU_DONE_o = (state_q == StDone);
  assign MDU_RD_o   = rd_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a scoreboard plus flush, reset,
// START/FLUSH collision and held-START sequences.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] rd;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  mdu dut (
    .clk         (clk),
    .rst         (rst),
    .MDU_START_i (start),
    .MDU_FLUSH_i (flush),
    .MDU_OP_i    (op),
    .MDU_RS1_i   (rs1),
    .MDU_RS2_i   (rs2),
    .MDU_BUSY_o  (busy),
    .MDU_DONE_o  (done),
    .MDU_RD_o    (rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        vecs[22];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] last_rd = 32'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DONE_o with nothing pending, got rd=%h at cycle %0d",
                 rd, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check(e.name, rd, e.rd);
        last_rd = e.rd;
      end
    end
  end

  function automatic int lat_of(input logic [2:0] o);
    return o[2] ? DivLat : MulLat;
  endfunction

  // Drives one START cycle; optionally records the expected completion.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] x, input bit expect_done);
    exp_t t;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    if (expect_done) begin
      t.name = name;
      t.rd   = x;
      t.cyc  = cyc + lat_of(o);
      sb.push_back(t);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy=%b pending=%0d after %0d cycles", busy, sb.size(), n);
      sb.delete();
    end
  endtask

  initial begin
    exp_t t;
    int   n0, d0;
    vecs[0]  = '{"mul_m1",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[1]  = '{"mulh_m1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2]  = '{"mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3]  = '{"mulhu_m1",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{"div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{"rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{"divu_100_7",  3'b101, 32'd100,      32'd7,        32'h0000000E};
    vecs[7]  = '{"remu_100_7",  3'b111, 32'd100,      32'd7,        32'h00000002};
    vecs[8]  = '{"div_7_0",     3'b100, 32'd7,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{"divu_7_0",    3'b101, 32'd7,        32'd0,        32'hFFFFFFFF};
    vecs[10] = '{"rem_7_0",     3'b110, 32'd7,        32'd0,        32'h00000007};
    vecs[11] = '{"remu_7_0",    3'b111, 32'd7,        32'd0,        32'h00000007};
    vecs[12] = '{"div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{"rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{"mul_plain",   3'b000, 32'h12345678, 32'd9,        32'hA3D70A38};
    vecs[15] = '{"mulh_m2_3",   3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vecs[16] = '{"div_m7_0",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[17] = '{"rem_m7_0",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[18] = '{"divu_big",    3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
    vecs[19] = '{"div_7_m2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[20] = '{"rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001};
    vecs[21] = '{"mulhu_big",   3'b011, 32'h80000000, 32'h00000004, 32'h00000002};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_idle();
    end

    // Flush at k+10 of a DIVU, then restart at k+11.
    @(negedge clk);
    n0 = cyc;
    start = 1'b1; op = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", {31'd0, busy}, 32'd0);
    check("flush_rd_kept", rd, last_rd);
    start = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    t.name = "after_flush"; t.rd = 32'h0000000E; t.cyc = cyc + 33;
    check("after_flush_at_k44", 32'(t.cyc), 32'(n0 + 44));
    sb.push_back(t);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Async reset mid-CALC.
    @(negedge clk);
    n0 = cyc;
    start = 1'b1; op = 3'b101; rs1 = 32'd55; rs2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_rd", rd, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    issue("after_reset", 3'b101, 32'd55, 32'd5, 32'd11, 1'b1);
    wait_idle();

    // START and FLUSH together in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b100; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("start_flush_rd", rd, last_rd);

    // START held high: accepted at k and k+34 only.
    d0 = done_cnt;
    @(negedge clk);
    n0 = cyc;
    start = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    t.name = "held_1"; t.rd = 32'h0000000E; t.cyc = n0 + 33;
    sb.push_back(t);
    t.name = "held_2"; t.cyc = n0 + 67;
    sb.push_back(t);
    repeat (35) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("held_done_count", 32'(done_cnt - d0), 32'd2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
